// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register between two stages: valid/ready handshake, stall, flush,
// and an optional 2-entry skid buffer that takes ready_i out of the ready_o path.
module pipe_stage_skid #(
   parameter int unsigned DATA_W         = 256,
   parameter int unsigned CTRL_W         = 16,
   parameter bit          SKID           = 1'b1,
   parameter bit          FLUSH_CLR_DATA = 1'b1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [DATA_W-1:0] data_i,
   input  logic [CTRL_W-1:0] ctrl_i,
   input  logic              flush_i,
   input  logic              stall_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [DATA_W-1:0] data_o,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic [1:0]        count_o
);

   // Handshake: an entry moves on a rising edge when valid and ready are both high.
   // Upstream holds valid_i and its payload until accepted; stall_i masks ready_i and
   // flush_i blocks acceptance, so neither side moves an entry while they are high.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic                in_fire, out_fire;
   logic                load_main_in, load_main_skid, load_skid;
   logic [DATA_W-1:0]   main_data_q, skid_data_q;
   logic [CTRL_W-1:0]   main_ctrl_q, skid_ctrl_q;

   assign valid_o  = (state_q != EMPTY);
   assign count_o  = state_q;
   assign data_o   = main_data_q;
   // An empty stage must look like a NOP downstream, never stale control.
   assign ctrl_o   = valid_o ? main_ctrl_q : '0;
   assign in_fire  = valid_i & ready_o & ~flush_i;
   assign out_fire = valid_o & ready_i & ~stall_i;

   if (SKID) begin : g_skid_ready
      assign ready_o = (state_q != FULL);
   end else begin : g_direct_ready
      assign ready_o = ~valid_o | (ready_i & ~stall_i);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // With SKID=0 the ONE->FULL arc is unreachable: in ONE, ready_o implies out_fire.
   always_comb begin
      state_d        = state_q;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      unique case (state_q)
         EMPTY: begin
            if (in_fire) begin
               state_d      = ONE;
               load_main_in = 1'b1;
            end
         end
         ONE: begin
            if (in_fire && out_fire) begin
               load_main_in = 1'b1;
            end else if (in_fire) begin
               state_d   = FULL;
               load_skid = 1'b1;
            end else if (out_fire) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (out_fire) begin
               state_d        = ONE;
               load_main_skid = 1'b1;
            end
         end
         default: state_d = EMPTY;
      endcase
      if (flush_i) begin
         state_d        = EMPTY;
         load_main_in   = 1'b0;
         load_main_skid = 1'b0;
         load_skid      = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         main_data_q <= '0;
         main_ctrl_q <= '0;
      end else if (flush_i) begin
         if (FLUSH_CLR_DATA) begin
            main_data_q <= '0;
         end
         main_ctrl_q <= '0;
      end else if (load_main_in) begin
         main_data_q <= data_i;
         main_ctrl_q <= ctrl_i;
      end else if (load_main_skid) begin
         main_data_q <= skid_data_q;
         main_ctrl_q <= skid_ctrl_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         skid_data_q <= '0;
         skid_ctrl_q <= '0;
      end else if (flush_i || load_main_skid) begin
         skid_data_q <= '0;
         skid_ctrl_q <= '0;
      end else if (load_skid) begin
         skid_data_q <= data_i;
         skid_ctrl_q <= ctrl_i;
      end
   end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed vector table on a SKID=1 instance, hand sequences
// for reset and the SKID=0 ready path, then scoreboard-checked random traffic on both.
module tb_pipe_stage_skid;

   localparam int DW = 32;
   localparam int CW = 8;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic          valid_i = 1'b0;
   logic [DW-1:0] data_i = '0;
   logic [CW-1:0] ctrl_i = '0;
   logic          flush_i = 1'b0;
   logic          stall_i = 1'b0;
   logic          ready_i = 1'b1;

   logic          s_ready_o, s_valid_o, n_ready_o, n_valid_o;
   logic [DW-1:0] s_data_o, n_data_o;
   logic [CW-1:0] s_ctrl_o, n_ctrl_o;
   logic [1:0]    s_count_o, n_count_o;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk_i = ~clk_i;

   pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b1), .FLUSH_CLR_DATA(1'b1)) dut_s (
      .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(s_ready_o),
      .data_i(data_i), .ctrl_i(ctrl_i), .flush_i(flush_i), .stall_i(stall_i),
      .valid_o(s_valid_o), .ready_i(ready_i), .data_o(s_data_o), .ctrl_o(s_ctrl_o),
      .count_o(s_count_o)
   );

   pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b0), .FLUSH_CLR_DATA(1'b1)) dut_n (
      .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(n_ready_o),
      .data_i(data_i), .ctrl_i(ctrl_i), .flush_i(flush_i), .stall_i(stall_i),
      .valid_o(n_valid_o), .ready_i(ready_i), .data_o(n_data_o), .ctrl_o(n_ctrl_o),
      .count_o(n_count_o)
   );

   typedef struct {
      logic          valid;
      logic [DW-1:0] data;
      logic [CW-1:0] ctrl;
      logic          ready;
      logic          stall;
      logic          flush;
      logic          e_valid;
      logic [DW-1:0] e_data;
      logic [CW-1:0] e_ctrl;
      logic [1:0]    e_count;
      logic          e_ready;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [DW-1:0] dval(input int k);
      return 32'hD000_0000 + k;
   endfunction

   function automatic logic [CW-1:0] cval(input int k);
      logic [31:0] kk;
      kk = k;
      return 8'hC0 + kk[7:0];
   endfunction

   // Inputs for one cycle, then the outputs expected just after that cycle's edge.
   // ek < 0 means data_o expected to be zero.
   function automatic void add(input bit v, input int k, input bit r, input bit s, input bit f,
                               input bit ev, input int ek, input int ec, input bit er);
      vec_t t;
      t.valid   = v;
      t.data    = dval(k);
      t.ctrl    = cval(k);
      t.ready   = r;
      t.stall   = s;
      t.flush   = f;
      t.e_valid = ev;
      t.e_data  = (ek < 0) ? '0 : dval(ek);
      t.e_ctrl  = ev ? cval(ek) : '0;
      t.e_count = 2'(ec);
      t.e_ready = er;
      vecs.push_back(t);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic reset_pulse();
      @(negedge clk_i);
      rst_ni  = 1'b0;
      valid_i = 1'b0;
      flush_i = 1'b0;
      stall_i = 1'b0;
      ready_i = 1'b1;
      @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   task automatic run_random(input bit sel, input int n);
      logic [DW+CW-1:0] exp_q[$];
      logic             acc, up_v, up_r, in_f, out_f, exp_r;
      logic [DW-1:0]    up_d;
      logic [CW-1:0]    up_c;
      logic [1:0]       up_n;
      int               outs;
      string            tag;
      tag  = sel ? "skid" : "noskid";
      outs = 0;
      acc  = 1'b0;
      reset_pulse();
      for (int c = 0; c < n; c++) begin
         @(negedge clk_i);
         if (!valid_i || acc) begin
            valid_i = ($urandom_range(0, 3) != 0);
            data_i  = $urandom;
            ctrl_i  = CW'($urandom_range(0, 255));
         end
         ready_i = ($urandom_range(0, 3) != 0);
         stall_i = ($urandom_range(0, 7) == 0);
         flush_i = 1'b0;
         #1;
         up_v = sel ? s_valid_o : n_valid_o;
         up_r = sel ? s_ready_o : n_ready_o;
         up_d = sel ? s_data_o  : n_data_o;
         up_c = sel ? s_ctrl_o  : n_ctrl_o;
         up_n = sel ? s_count_o : n_count_o;
         check({tag, " count"}, up_n, exp_q.size());
         exp_r = sel ? (exp_q.size() < 2) : (exp_q.size() == 0) | (ready_i & ~stall_i);
         check({tag, " ready"}, up_r, exp_r);
         if (exp_q.size() == 0) check({tag, " idle ctrl"}, up_c, 0);
         in_f  = valid_i & up_r;
         out_f = up_v & ready_i & ~stall_i;
         if (out_f) begin
            outs++;
            if (exp_q.size() == 0) check({tag, " spurious output"}, 1, 0);
            else check({tag, " output entry"}, {up_c, up_d}, exp_q.pop_front());
         end
         if (in_f) exp_q.push_back({ctrl_i, data_i});
         acc = in_f;
      end
      check({tag, " outputs seen"}, outs > n / 4, 1);
      @(negedge clk_i);
      valid_i = 1'b0;
   endtask

   initial begin
      // Reset with a live input entry on the bus
      rst_ni  = 1'b0;
      valid_i = 1'b1;
      data_i  = 32'hAA;
      ctrl_i  = 8'h5A;
      #1;
      check("reset valid_o", s_valid_o, 0);
      check("reset ctrl_o", s_ctrl_o, 0);
      check("reset data_o", s_data_o, 0);
      check("reset count_o", s_count_o, 0);
      check("reset ready_o", s_ready_o, 1);
      @(posedge clk_i); #1;
      check("reset held valid_o", s_valid_o, 0);
      @(negedge clk_i);
      valid_i = 1'b0;
      rst_ni  = 1'b1;

      // Streaming D1..D8, then drain
      for (int k = 1; k <= 8; k++) add(1, k, 1, 0, 0, 1, k, 1, 1);
      add(0, 0, 1, 0, 0, 0, 8, 0, 1);
      // Back-pressure: D11 out, D12 in skid, D13 held upstream
      add(1, 11, 0, 0, 0, 1, 11, 1, 1);
      add(1, 12, 0, 0, 0, 1, 11, 2, 0);
      add(1, 13, 0, 0, 0, 1, 11, 2, 0);
      add(1, 13, 1, 0, 0, 1, 12, 1, 1);
      add(1, 13, 1, 0, 0, 1, 13, 1, 1);
      add(0, 0, 1, 0, 0, 0, 13, 0, 1);
      // Stall holds D5 for 4 cycles, then it leaves exactly once
      add(1, 5, 1, 0, 0, 1, 5, 1, 1);
      for (int k = 0; k < 4; k++) add(0, 0, 1, 1, 0, 1, 5, 1, 1);
      add(0, 0, 1, 0, 0, 0, 5, 0, 1);
      add(0, 0, 1, 0, 0, 0, 5, 0, 1);
      // Flush while full, D9 dropped
      add(1, 6, 0, 0, 0, 1, 6, 1, 1);
      add(1, 7, 0, 0, 0, 1, 6, 2, 0);
      add(1, 9, 0, 0, 1, 0, -1, 0, 1);
      add(0, 0, 1, 0, 0, 0, -1, 0, 1);
      // Flush together with stall
      add(1, 6, 0, 0, 0, 1, 6, 1, 1);
      add(1, 7, 0, 0, 0, 1, 6, 2, 0);
      add(1, 9, 1, 1, 1, 0, -1, 0, 1);
      add(0, 0, 1, 0, 0, 0, -1, 0, 1);
      // Flush from a single held entry
      add(1, 4, 1, 0, 0, 1, 4, 1, 1);
      add(1, 9, 1, 0, 1, 0, -1, 0, 1);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk_i);
         valid_i = vecs[i].valid;
         data_i  = vecs[i].data;
         ctrl_i  = vecs[i].ctrl;
         ready_i = vecs[i].ready;
         stall_i = vecs[i].stall;
         flush_i = vecs[i].flush;
         @(posedge clk_i); #1;
         check($sformatf("vec%0d valid_o", i), s_valid_o, vecs[i].e_valid);
         check($sformatf("vec%0d data_o", i), s_data_o, vecs[i].e_data);
         check($sformatf("vec%0d ctrl_o", i), s_ctrl_o, vecs[i].e_ctrl);
         check($sformatf("vec%0d count_o", i), s_count_o, vecs[i].e_count);
         check($sformatf("vec%0d ready_o", i), s_ready_o, vecs[i].e_ready);
      end

      // Reset asserted while the skid stage is full
      @(negedge clk_i);
      valid_i = 1'b1; data_i = dval(1); ctrl_i = cval(1); ready_i = 1'b0;
      stall_i = 1'b0; flush_i = 1'b0;
      @(negedge clk_i);
      data_i = dval(2); ctrl_i = cval(2);
      @(negedge clk_i);
      check("pre-reset count_o", s_count_o, 2);
      valid_i = 1'b0;
      #2 rst_ni = 1'b0;
      #1;
      check("mid reset count_o", s_count_o, 0);
      check("mid reset valid_o", s_valid_o, 0);
      check("mid reset data_o", s_data_o, 0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(posedge clk_i); #1;
      check("post reset ready_o", s_ready_o, 1);
      check("post reset count_o", s_count_o, 0);

      // SKID=0: ready_o follows downstream readiness in the same cycle
      @(negedge clk_i);
      valid_i = 1'b1; data_i = dval(21); ctrl_i = cval(21); ready_i = 1'b1;
      #1 check("noskid ready empty", n_ready_o, 1);
      @(posedge clk_i); #1;
      check("noskid valid D21", n_valid_o, 1);
      check("noskid data D21", n_data_o, dval(21));
      @(negedge clk_i);
      data_i = dval(22); ctrl_i = cval(22); ready_i = 1'b0;
      #1 check("noskid ready low", n_ready_o, 0);
      @(posedge clk_i); #1;
      check("noskid hold D21", n_data_o, dval(21));
      @(negedge clk_i);
      ready_i = 1'b1;
      #1 check("noskid ready high", n_ready_o, 1);
      @(posedge clk_i); #1;
      check("noskid data D22", n_data_o, dval(22));
      @(negedge clk_i);
      data_i = dval(23); ctrl_i = cval(23); stall_i = 1'b1;
      #1 check("noskid ready stalled", n_ready_o, 0);
      @(posedge clk_i); #1;
      check("noskid stall hold D22", n_data_o, dval(22));
      @(negedge clk_i);
      valid_i = 1'b0; stall_i = 1'b0;
      @(posedge clk_i); #1;
      check("noskid drained valid_o", n_valid_o, 0);
      check("noskid drained ctrl_o", n_ctrl_o, 0);

      run_random(1'b0, 10000);
      run_random(1'b1, 3000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

endmodule
